skullfet_wb_tester: RTL and testbench

- Wishbone responder that exercises a skullfet test cell from the Caravel bus.
- Drives a stimulus pad (io_out/io_oeb) with a programmable square wave.
- Samples the cell's output pad back through io_in, checks it against the expected inverted value, and counts toggles and mismatches.
- Sits in user_project_wrapper between the wbs_* bus and the pads wired to the skullfet cells.

---
 rtl/skullfet_tester_pkg.sv | 30 +++
 rtl/skullfet_sense_sync.sv | 34 +++
 rtl/skullfet_wb_tester.sv | 210 +++++++++++++++++++++
 tb/tb_skullfet_wb_tester.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skullfet_tester_pkg.sv
// Shared definitions for the skullfet Wishbone tester.
// Holds the register map offsets, CTRL/STATUS bit positions and the
// stimulus FSM state type used by skullfet_wb_tester.
package skullfet_tester_pkg;

  // Register offsets within the 256-byte responder window
  localparam logic [7:0] OffCtrl    = 8'h00;
  localparam logic [7:0] OffDiv     = 8'h04;
  localparam logic [7:0] OffSettle  = 8'h08;
  localparam logic [7:0] OffStatus  = 8'h0C;
  localparam logic [7:0] OffToggles = 8'h10;
  localparam logic [7:0] OffErrors  = 8'h14;

  // CTRL bit indices
  localparam int unsigned CtrlRun   = 0;
  localparam int unsigned CtrlOe    = 1;
  localparam int unsigned CtrlIrqEn = 2;
  localparam int unsigned CtrlClr   = 3;

  // STATUS bit indices
  localparam int unsigned StatBusy  = 0;
  localparam int unsigned StatErr   = 1;
  localparam int unsigned StatSense = 2;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/skullfet_sense_sync.sv
// Two-flop synchronizer for the asynchronous sense pad, plus a third flop
// for rising-edge detection.
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous active-high reset
//   sense_i - asynchronous cell output (io_in)
//   sync_o  - synchronized sense level
//   rise_o  - one-cycle pulse on a rising edge of sync_o
module skullfet_sense_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sense_i,
  output logic sync_o,
  output logic rise_o
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], sense_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/skullfet_wb_tester.sv
// Wishbone responder that drives a skullfet test cell with a programmable
// square wave and checks the cell's inverted response.
// Ports:
//   wb_clk_i, wb_rst_i      - clock and synchronous active-high reset
//   wbs_*                   - Wishbone classic slave (ack one cycle after hit)
//   stim_o, stim_oeb_o      - stimulus pad data and output-enable-bar
//   sense_i                 - asynchronous cell output pad
//   irq_o                   - level interrupt (irq_en & err_sticky, registered)
module skullfet_wb_tester
  import skullfet_tester_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned DIV_W     = 16,  // must be >= 8 so SETTLE fits the phase
  parameter int unsigned CNT_W     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        stim_o,
  output logic        stim_oeb_o,
  input  logic        sense_i,
  output logic        irq_o
);

  logic             ack_q, ack_d;
  logic             run_q, run_d;
  logic             oe_q, oe_d;
  logic             irq_en_q, irq_en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       settle_q, settle_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] toggles_q, toggles_d;
  logic [CNT_W-1:0] errors_q, errors_d;
  logic             stim_q, stim_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic             irq_q, irq_d;
  state_e           state_q, state_d;

  logic        hit, wr, clr, err_clr, mismatch;
  logic        sense_sync, sense_rise;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{wbs_dat_i, wbs_sel_i};

  skullfet_sense_sync u_sense_sync (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .sense_i (sense_i),
    .sync_o  (sense_sync),
    .rise_o  (sense_rise)
  );

  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // The ack cycle is the write-apply cycle; the master holds its request until it sees ack.
  assign wr  = ack_q & wbs_cyc_i & wbs_stb_i & wbs_we_i;

  always_comb begin
    // Ack drops for one cycle after each ack, so a held strobe gets every other cycle.
    ack_d        = hit & ~ack_q;
    run_d        = run_q;
    oe_d         = oe_q;
    irq_en_d     = irq_en_q;
    div_d        = div_q;
    settle_d     = settle_q;
    clr          = 1'b0;
    err_clr      = 1'b0;
    if (wr) begin
      case (wbs_adr_i[7:0])
        OffCtrl: begin
          if (wbs_sel_i[0]) begin
            run_d    = wbs_dat_i[CtrlRun];
            oe_d     = wbs_dat_i[CtrlOe];
            irq_en_d = wbs_dat_i[CtrlIrqEn];
            clr      = wbs_dat_i[CtrlClr];
          end
        end
        OffDiv: begin
          for (int i = 0; i < DIV_W; i++) begin
            if (wbs_sel_i[i[4:3]]) div_d[i] = wbs_dat_i[i];
          end
        end
        OffSettle: if (wbs_sel_i[0]) settle_d = wbs_dat_i[7:0];
        OffStatus: if (wbs_sel_i[0]) err_clr = wbs_dat_i[StatErr];
        default: ;
      endcase
    end

    state_d  = state_q;
    phase_d  = phase_q;
    stim_d   = stim_q;
    mismatch = 1'b0;
    case (state_q)
      StIdle: begin
        if (run_q) begin
          state_d = StRun;
          phase_d = '0;
        end
      end
      StRun: begin
        if (!run_q) begin
          state_d = StIdle;
        end else begin
          phase_d = phase_q + DIV_W'(1);
          // The cell inverts, so a healthy response equals ~stim.
          if (phase_q == DIV_W'(settle_q)) mismatch = (sense_sync == stim_q);
          if (phase_q == div_q) begin
            stim_d  = ~stim_q;
            phase_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Clears win over simultaneous increments/sets.
    if (clr) begin
      toggles_d = '0;
    end else if (sense_rise && (toggles_q != '1)) begin
      toggles_d = toggles_q + CNT_W'(1);
    end else begin
      toggles_d = toggles_q;
    end

    if (clr) begin
      errors_d = '0;
    end else if (mismatch && (errors_q != '1)) begin
      errors_d = errors_q + CNT_W'(1);
    end else begin
      errors_d = errors_q;
    end

    if (clr || err_clr) begin
      err_sticky_d = 1'b0;
    end else if (mismatch) begin
      err_sticky_d = 1'b1;
    end else begin
      err_sticky_d = err_sticky_q;
    end

    irq_d = irq_en_q & err_sticky_q;
  end

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[7:0])
      OffCtrl: begin
        rdata[CtrlRun]   = run_q;
        rdata[CtrlOe]    = oe_q;
        rdata[CtrlIrqEn] = irq_en_q;
      end
      OffDiv:     rdata[DIV_W-1:0] = div_q;
      OffSettle:  rdata[7:0]       = settle_q;
      OffStatus: begin
        rdata[StatBusy]  = (state_q == StRun);
        rdata[StatErr]   = err_sticky_q;
        rdata[StatSense] = sense_sync;
      end
      OffToggles: rdata[CNT_W-1:0] = toggles_q;
      OffErrors:  rdata[CNT_W-1:0] = errors_q;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q        <= 1'b0;
      run_q        <= 1'b0;
      oe_q         <= 1'b0;
      irq_en_q     <= 1'b0;
      div_q        <= '0;
      settle_q     <= '0;
      err_sticky_q <= 1'b0;
      toggles_q    <= '0;
      errors_q     <= '0;
      stim_q       <= 1'b0;
      phase_q      <= '0;
      irq_q        <= 1'b0;
      state_q      <= StIdle;
    end else begin
      ack_q        <= ack_d;
      run_q        <= run_d;
      oe_q         <= oe_d;
      irq_en_q     <= irq_en_d;
      div_q        <= div_d;
      settle_q     <= settle_d;
      err_sticky_q <= err_sticky_d;
      toggles_q    <= toggles_d;
      errors_q     <= errors_d;
      stim_q       <= stim_d;
      phase_q      <= phase_d;
      irq_q        <= irq_d;
      state_q      <= state_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = ack_q ? rdata : 32'h0;
  assign stim_o     = stim_q;
  assign stim_oeb_o = ~oe_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_skullfet_wb_tester.sv
module tb_skullfet_wb_tester;

  localparam logic [31:0] Base      = 32'h3000_0000;
  localparam logic [7:0]  RCtrl     = 8'h00;
  localparam logic [7:0]  RDiv      = 8'h04;
  localparam logic [7:0]  RSettle   = 8'h08;
  localparam logic [7:0]  RStatus   = 8'h0C;
  localparam logic [7:0]  RToggles  = 8'h10;
  localparam logic [7:0]  RErrors   = 8'h14;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  logic        ack, stim, oeb, sense, irq;

  int errors = 0;
  int checks = 0;
  bit sense_tie0 = 1'b1;
  logic [32:0] exp_q[$];

  skullfet_wb_tester dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .stim_o     (stim),
    .stim_oeb_o (oeb),
    .sense_i    (sense),
    .irq_o      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cell model: inverted stimulus seen one edge later, or tied low.
  initial begin
    sense = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sense = sense_tie0 ? 1'b0 : ~stim;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // One Wishbone access. Returns data seen on the ack cycle, edges until ack,
  // and ack level one cycle later with the strobe still held.
  task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output int lat,
                     output logic ack_late);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = Base | {24'h0, off}; wdat = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 8);
    rd = rdat;
    @(posedge clk); #1;
    ack_late = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] rd; int lat; logic al;
    bus(1'b1, off, d, 4'hF, rd, lat, al);
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; logic al; logic [32:0] e;
    rst = 1'b1; sense_tie0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack, rdat, stim, oeb, irq} !== {1'b0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", {ack, rdat, stim, oeb, irq},
               {1'b0, 32'h0, 1'b0, 1'b1, 1'b0});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b1, 32'h0});
    for (int i = 0; i < 6; i++) begin
      bus(1'b0, 8'(i * 4), 32'h0, 4'hF, rd, lat, al);
      e = exp_q.pop_front();
      checks++;
      if ({lat == 1, rd} !== e) begin
        errors++;
        $display("FAIL reset_read_%0d: got %h want %h", i, {lat == 1, rd}, e);
      end
      checks++;
      if (al !== 1'b0) begin
        errors++;
        $display("FAIL ack_width_%0d: got %b want 0", i, al);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int lat; logic al; logic [32:0] e;
    wb_write(RDiv, 32'h0000_1234);
    bus(1'b1, RDiv, 32'hFFFF_ABCD, 4'b0010, rd, lat, al);   // only byte 1 lands
    bus(1'b1, RSettle, 32'h0000_00FF, 4'b0000, rd, lat, al); // no lanes: ignored
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = Base | 32'h4;
    for (int i = 0; i < 6; i++)
      exp_q.push_back({(i % 2) == 0, ((i % 2) == 0) ? 32'h0000_AB34 : 32'h0});
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({ack, rdat} !== e) begin
        errors++;
        $display("FAIL b2b_edge_%0d: got %h want %h", i, {ack, rdat}, e);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 32'h0});
    bus(1'b0, RSettle, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL settle_sel0: got %h want %h", {lat == 1, rd}, e);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; int lat; logic al; logic [32:0] e;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = Base + 32'h100;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0) begin
        errors++;
        $display("FAIL outside_ack_%0d: got %b want 0", i, ack);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    wb_write(8'h40, 32'hFFFF_FFFF);
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    bus(1'b0, 8'h40, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL unmapped_read: got %h want %h", {lat == 1, rd}, e);
    end
    bus(1'b0, RCtrl, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL unmapped_no_alias: got %h want %h", {lat == 1, rd}, e);
    end
  endtask

  task automatic test_square();
    logic [31:0] rd; int lat; logic al; logic [32:0] e;
    int falls, guard, last_rise; logic prev;
    sense_tie0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    wb_write(RCtrl, 32'h8);
    wb_write(RDiv, 32'd3);
    wb_write(RSettle, 32'd2);
    wb_write(RCtrl, 32'h3);
    falls = 0; guard = 0; last_rise = -1; prev = stim;
    while (falls < 10 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
      if (stim && !prev) begin
        if (last_rise >= 0) begin
          checks++;
          if (guard - last_rise != 8) begin
            errors++;
            $display("FAIL stim_period: got %0d want 8", guard - last_rise);
          end
        end
        last_rise = guard;
      end
      if (!stim && prev) falls++;
      prev = stim;
    end
    checks++;
    if (falls != 10) begin
      errors++;
      $display("FAIL stim_falls: got %0d want 10", falls);
    end
    wb_write(RCtrl, 32'h2);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({stim, oeb} !== 2'b00) begin
      errors++;
      $display("FAIL stim_hold_oe: got %b want 00", {stim, oeb});
    end
    exp_q.push_back({1'b1, 32'd10});
    exp_q.push_back({1'b1, 32'd0});
    exp_q.push_back({1'b1, 32'h4});
    bus(1'b0, RToggles, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL toggles_10: got %h want %h", {lat == 1, rd}, e);
    end
    bus(1'b0, RErrors, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL errors_0: got %h want %h", {lat == 1, rd}, e);
    end
    bus(1'b0, RStatus, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL status_idle_sense: got %h want %h", {lat == 1, rd}, e);
    end
  endtask

  task automatic test_errors_irq();
    logic [31:0] rd; int lat; logic al; logic [32:0] e;
    logic any_irq; int guard; logic prev;
    sense_tie0 = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wb_write(RDiv, 32'd3);
    wb_write(RSettle, 32'd2);
    wb_write(RCtrl, 32'h7);
    // First check lands four edges after run is applied; clr is timed onto that edge.
    repeat (2) @(posedge clk);
    #1;
    wb_write(RCtrl, 32'hF);
    any_irq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      any_irq |= irq;
    end
    checks++;
    if (any_irq !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority_irq: got %b want 0", any_irq);
    end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    // stim just rose; stop after the next rise, inside the high phase.
    guard = 0; prev = stim;
    while (!(stim && !prev) && guard < 40) begin
      prev = stim;
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      errors++;
      $display("FAIL stim_rise_wait: got timeout want rise");
    end
    wb_write(RCtrl, 32'h6);
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 32'd2});
    exp_q.push_back({1'b1, 32'h2});
    exp_q.push_back({1'b1, 32'h0});
    bus(1'b0, RErrors, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL errors_count: got %h want %h", {lat == 1, rd}, e);
    end
    bus(1'b0, RStatus, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL status_sticky: got %h want %h", {lat == 1, rd}, e);
    end
    wb_write(RStatus, 32'h2);
    bus(1'b0, RStatus, 32'h0, 4'hF, rd, lat, al);
    e = exp_q.pop_front();
    checks++;
    if ({lat == 1, rd} !== e) begin
      errors++;
      $display("FAIL status_w1c: got %h want %h", {lat == 1, rd}, e);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b want 0", irq);
    end
  endtask

  task automatic test_reset_run();
    logic [31:0] rd; int lat; logic al; logic [32:0] e; int guard;
    sense_tie0 = 1'b0;
    wb_write(RDiv, 32'd3);
    wb_write(RSettle, 32'd2);
    wb_write(RCtrl, 32'h3);
    guard = 0;
    while (stim !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (stim !== 1'b1) begin
      errors++;
      $display("FAIL reset_run_setup: got %b want 1", stim);
    end
    sense_tie0 = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({stim, oeb, irq, ack} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_run_outputs: got %b want 0100", {stim, oeb, irq, ack});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 32'h0});
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, (i == 0) ? RCtrl : (i == 1) ? RStatus : (i == 2) ? RToggles : RErrors,
          32'h0, 4'hF, rd, lat, al);
      e = exp_q.pop_front();
      checks++;
      if ({lat == 1, rd} !== e) begin
        errors++;
        $display("FAIL reset_run_reg_%0d: got %h want %h", i, {lat == 1, rd}, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    test_reset();
    test_back_to_back();
    test_unmapped();
    test_square();
    test_errors_irq();
    test_reset_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
